wb_port_arbiter: RTL
====================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 15, cycles a grant may be held without done before forced release (used only with ARB_TIMEOUT_EN).
REQ-002 Port: clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: resetn  input  1  reset, synchronous and active-low.
REQ-004 Port: req  input  8  per-requester write-port request; bit i = requester i.
REQ-005 Port: done  input  1  granted requester finished its transfer this cycle.
REQ-006 Port: grant  output  8  one-hot grant; all-zero when no grant is active.
REQ-007 Port: grant_idx  output  3  binary index of the granted requester; holds the last value when grant_valid=0.
REQ-008 Port: grant_valid  output  1  a grant is active.
REQ-009 Port: timeout  output  1  one-cycle pulse on forced release.

Function
REQ-010 The block SHALL implement two states: IDLE (no grant) and GRANT (one requester owns the port).
REQ-011 grant SHALL equal the 3-to-8 one-hot decode of grant_idx (decoder_8val) gated by grant_valid, so at most one bit is ever set.
REQ-012 The round-robin pointer ptr (3 bits) SHALL mark the highest-priority requester; the search order is ptr, ptr+1, ..., ptr+7, modulo 8.
REQ-013 IDLE: if req is non-zero, the block SHALL register the first set bit in search order into grant_idx, set grant_valid, and enter GRANT; first grant is visible one cycle after req is sampled.
REQ-014 IDLE with req=0: all state SHALL hold.
REQ-015 GRANT: grant SHALL hold unchanged while req[grant_idx]=1 and done=0, regardless of other req bits.
REQ-016 Release occurs on done=1, or on req[grant_idx]=0 (requester withdrew); both events in the same cycle count as a single release.
REQ-017 On release, ptr SHALL become grant_idx+1 modulo 8 (7 wraps to 0).
REQ-018 On release with another req bit set (the current index excluded), the next grant SHALL be registered in the same edge using the updated ptr: back-to-back grants with zero idle cycles, no cycle with grant_valid=0.
REQ-019 On release with no other req bit set, the block SHALL clear grant_valid and enter IDLE.
REQ-020 done while grant_valid=0 SHALL be ignored.
REQ-021 No requester SHALL wait more than 7 grants once its req is held high (starvation bound).

Reset
REQ-022 resetn=0 at a rising edge SHALL force IDLE, grant_valid=0, grant=8'h00, grant_idx=3'd0, ptr=3'd0, timeout=0, and clear the timeout counter.
REQ-023 Reset mid-grant SHALL abort the grant without a timeout pulse; arbitration resumes on the first edge with resetn=1.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN defined: a counter SHALL clear on every new grant and increment each GRANT cycle without release.
REQ-025 ARB_TIMEOUT_EN defined: when the counter reaches TIMEOUT with no release, the block SHALL force release per REQ-017 to REQ-019 and pulse timeout for exactly one cycle.
REQ-026 ARB_TIMEOUT_EN defined, done arriving in the same cycle as expiry: the release SHALL be treated as normal and timeout SHALL stay 0.
REQ-027 ARB_TIMEOUT_EN undefined: no counter SHALL be built, timeout SHALL be tied to 0, and grants hold indefinitely.

Verification
REQ-028 Reset, then req=8'h00 for 5 cycles -> grant=8'h00, grant_valid=0, grant_idx=0 throughout.
REQ-029 req=8'b1000_0001 held, done pulsed each grant cycle -> grant sequence 01, 80, 01, 80, with no idle cycle between grants.
REQ-030 ptr=7 via a grant to requester 6 and done, then req=8'b0100_0001 -> grant to 0 before 6 (wrap-around).
REQ-031 Granted requester 3 drops req[3] with done=0 and req=8'h00 -> next cycle grant_valid=0, IDLE, ptr=4.
REQ-032 ARB_TIMEOUT_EN, TIMEOUT=4, req=8'h04 held, done=0 -> release after 4 grant cycles, timeout high one cycle, re-grant to 2; same test without the macro -> grant holds, timeout=0.
REQ-033 resetn=0 asserted during an active grant to requester 5 -> next cycle all outputs at reset values, no timeout pulse.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Eight-requester round-robin write-port arbiter with a hold-until-done grant.
// Define ARB_TIMEOUT_EN to build the forced-release timer (limit set by TIMEOUT).
module wb_port_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout,
  output logic       dbg_state,
  output logic [2:0] dbg_ptr
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] others;
  logic       rel_norm;
  logic       expire;
  logic       release_now;
  logic       new_grant;

  function automatic logic [7:0] decoder_8val(input logic [2:0] idx);
    decoder_8val = 8'b0000_0001 << idx;
  endfunction

  // Scan from the far end so the first set bit in search order wins.
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] k;
    pick = p;
    for (int i = 7; i >= 0; i--) begin
      k = p + i[2:0];
      if (r[k]) pick = k;
    end
  endfunction

  assign others      = req & ~decoder_8val(idx_q);
  assign rel_norm    = done | ~req[idx_q];
  assign release_now = (state_q == GRANT) && (rel_norm || expire);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    ptr_d     = ptr_q;
    new_grant = 1'b0;
    if (state_q == IDLE) begin
      if (|req) begin
        idx_d     = pick(req, ptr_q);
        valid_d   = 1'b1;
        state_d   = GRANT;
        new_grant = 1'b1;
      end
    end else if (release_now) begin
      ptr_d = idx_q + 3'd1;
      // Back-to-back handoff uses the already-advanced pointer.
      if (|others) begin
        idx_d     = pick(others, ptr_d);
        new_grant = 1'b1;
      end else begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
      ptr_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  // Expiry fires on the TIMEOUT-th grant cycle, so the grant lasts TIMEOUT cycles.
  assign expire = (state_q == GRANT) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (new_grant)                          cnt_d = '0;
    else if (state_q == GRANT && !release_now) cnt_d = cnt_q + 1'b1;
    timeout_d = expire && !rel_norm;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_cfg;
  assign expire     = 1'b0;
  assign timeout    = 1'b0;
  assign unused_cfg = ^{TIMEOUT, new_grant};
`endif

  assign grant       = valid_q ? decoder_8val(idx_q) : 8'h00;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign dbg_state   = state_q;
  assign dbg_ptr     = ptr_q;

endmodule
